// File: rtl/backend_pkg.sv
// Shared types and arithmetic helpers for the accumulate/drain backend.
// All helpers work on a 64-bit signed carrier so that one set of functions
// serves every ACC_W/OUT_W instantiation (ACC_W+1 must stay <= 64).
package backend_pkg;

    localparam int WIDE_W = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Largest value representable in a w-bit signed field.
    function automatic wide_t max_of(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    // Smallest value representable in a w-bit signed field.
    function automatic wide_t min_of(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // True when v does not fit in a w-bit signed field.
    function automatic logic clips(input wide_t v, input int w);
        return (v > max_of(w)) || (v < min_of(w));
    endfunction

    function automatic wide_t sat_clamp(input wide_t v, input int w);
        wide_t r;
        if (v > max_of(w)) begin
            r = max_of(w);
        end else if (v < min_of(w)) begin
            r = min_of(w);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Clamp an accumulator update to the acc_w-bit signed range.
    function automatic wide_t sat_acc(input wide_t v, input int acc_w);
        return sat_clamp(v, acc_w);
    endfunction

    // Clamp a drained value to the out_w-bit signed range.
    function automatic wide_t sat_out(input wide_t v, input int out_w);
        return sat_clamp(v, out_w);
    endfunction

    // Round-half-up arithmetic right shift used for average pooling.
    // The carrier is wider than ACC_W+1, so the bias add never wraps.
    function automatic wide_t round_shift(input wide_t v, input logic [5:0] sh);
        wide_t bias;
        bias = (sh == 6'd0) ? wide_t'(0) : (wide_t'(1) <<< (sh - 6'd1));
        return (v + bias) >>> sh;
    endfunction

endpackage

// File: rtl/backend_accum_engine_if.sv
// Product-beat input and drained-word output handshakes of the accumulator engine.
interface backend_accum_engine_if #(
    parameter int PROD_W = 17,
    parameter int LANES  = 16,
    parameter int RED    = 4,
    parameter int ADDR_W = 8,
    parameter int OUT_W  = 17
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*RED*PROD_W-1:0] in_products;
    logic [ADDR_W-1:0]         in_addr;
    logic                      in_first;

    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*OUT_W-1:0]    out_data;
    logic [ADDR_W-1:0]         out_addr;

    // Producer of beats and consumer of drained words.
    modport master (
        output in_valid, in_products, in_addr, in_first, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    // The engine itself.
    modport slave (
        input  in_valid, in_products, in_addr, in_first, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/backend_reduce_lane.sv
// One lane of stage S1: sums RED sign-extended products through a binary
// adder tree and registers the result. The output is log2(RED) bits wider
// than a product, so the tree can never overflow.
module backend_reduce_lane #(
    parameter int PROD_W = 17,
    parameter int RED    = 4,
    localparam int SUM_W = PROD_W + $clog2(RED)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [RED*PROD_W-1:0]   products,
    output logic signed [SUM_W-1:0] sum
);
    localparam int NODES = 2 * RED - 1;

    logic signed [SUM_W-1:0] leaf [RED];
    logic signed [SUM_W-1:0] node [NODES];

    genvar gi;
    generate
        for (gi = 0; gi < RED; gi++) begin : g_leaf
            assign leaf[gi] = SUM_W'($signed(products[gi*PROD_W +: PROD_W]));
        end
    endgenerate

    // Heap-ordered tree: leaves sit at RED-1.., node i adds children 2i+1 and 2i+2.
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < RED; i++) begin
            node[RED-1+i] = leaf[i];
        end
        for (int i = RED - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
    end

    // Capture the root only for accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= node[0];
        end
    end

endmodule

// File: rtl/backend_accum_engine.sv
// Accumulator engine: per-lane reduction (S1), saturating read-modify-write
// into the accumulator buffer (S2), and a handshaked drain that applies a
// rounding average-pool shift and output saturation.
module backend_accum_engine
    import backend_pkg::*;
#(
    parameter int PROD_W = 17,
    parameter int LANES  = 16,
    parameter int RED    = 4,
    parameter int ACC_W  = 44,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int OUT_W  = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    backend_accum_engine_if.slave bus,
    input  logic                  drain_start,
    input  logic [ADDR_W:0]       drain_count,
    input  logic [5:0]            drain_shift,
    output logic                  drain_done,
    output logic                  ovf,
    output logic                  busy
);
    localparam int SUM_W = PROD_W + $clog2(RED);

    // FSM and handshake decode
    state_t state_reg, state_next;
    logic   in_ready_c, start_c, load_c, busy_c;
    logic   accept, out_hs, last_hs;

    // Pipeline
    logic                    s1_valid_reg, s1_first_reg, s2_valid_reg;
    logic [ADDR_W-1:0]       s1_addr_reg;
    logic signed [SUM_W-1:0] lane_sum [LANES];

    // Accumulator buffer (not reset; software overwrites with in_first)
    logic signed [ACC_W-1:0] mem [DEPTH][LANES];
    logic signed [ACC_W-1:0] acc_new [LANES];
    logic [LANES-1:0]        acc_clip, out_clip;
    logic [LANES*OUT_W-1:0]  drain_word;

    // Drain datapath
    logic [ADDR_W:0]        count_reg;
    logic [5:0]             shift_reg;
    logic [ADDR_W-1:0]      rd_ptr_reg;
    logic                   out_valid_reg;
    logic [LANES*OUT_W-1:0] out_data_reg;
    logic [ADDR_W-1:0]      out_addr_reg;
    logic                   drain_done_reg, ovf_reg;

    assign accept  = bus.in_valid & in_ready_c;
    assign out_hs  = out_valid_reg & bus.out_ready;
    assign last_hs = out_hs && ({1'b0, out_addr_reg} == (count_reg - (ADDR_W+1)'(1)));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: FLUSH waits for both pipeline stages to drain into memory.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (drain_start) state_next = ST_FLUSH;
            ST_FLUSH: if (!s1_valid_reg && !s2_valid_reg) state_next = ST_DRAIN;
            ST_DRAIN: if (last_hs) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: beats only in IDLE; a word is loaded whenever the drain port is empty.
    always_comb begin
        in_ready_c = (state_reg == ST_IDLE);
        start_c    = (state_reg == ST_IDLE) && drain_start;
        load_c     = (state_reg == ST_DRAIN) && !out_valid_reg;
        busy_c     = (state_reg != ST_IDLE) || s1_valid_reg || s2_valid_reg;
    end

    // S1/S2 control: the address and overwrite flag travel alongside the lane sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_addr_reg  <= '0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s2_valid_reg <= s1_valid_reg;
            if (accept) begin
                s1_first_reg <= bus.in_first;
                s1_addr_reg  <= bus.in_addr;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            wide_t base_w, total_w, rnd_w;

            backend_reduce_lane #(
                .PROD_W (PROD_W),
                .RED    (RED)
            ) u_reduce (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (accept),
                .products (bus.in_products[gi*RED*PROD_W +: RED*PROD_W]),
                .sum      (lane_sum[gi])
            );

            // S2: combinational read, so consecutive beats to one entry see the fresh value.
            assign base_w       = s1_first_reg ? wide_t'(0) : wide_t'(mem[s1_addr_reg][gi]);
            assign total_w      = base_w + wide_t'(lane_sum[gi]);
            assign acc_clip[gi] = clips(total_w, ACC_W);
            assign acc_new[gi]  = ACC_W'(sat_acc(total_w, ACC_W));

            // Drain: rounding shift of the entry under rd_ptr, then clamp to OUT_W.
            assign rnd_w        = round_shift(wide_t'(mem[rd_ptr_reg][gi]), shift_reg);
            assign out_clip[gi] = clips(rnd_w, OUT_W);
            assign drain_word[gi*OUT_W +: OUT_W] = OUT_W'(sat_out(rnd_w, OUT_W));
        end
    endgenerate

    // Accumulator buffer write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (s1_valid_reg) begin
            for (int l = 0; l < LANES; l++) begin
                mem[s1_addr_reg][l] <= acc_new[l];
            end
        end
    end

    // Drain registers: latch the command, load a word when the port is empty, advance on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg      <= '0;
            shift_reg      <= '0;
            rd_ptr_reg     <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_addr_reg   <= '0;
            drain_done_reg <= 1'b0;
        end else begin
            drain_done_reg <= last_hs;
            if (start_c) begin
                count_reg  <= (drain_count == '0) ? (ADDR_W+1)'(1) : drain_count;
                shift_reg  <= drain_shift;
                rd_ptr_reg <= '0;
            end
            if (load_c) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= drain_word;
                out_addr_reg  <= rd_ptr_reg;
            end else if (out_hs) begin
                out_valid_reg <= 1'b0;
                rd_ptr_reg    <= rd_ptr_reg + ADDR_W'(1);
            end
        end
    end

    // Sticky overflow: a new drain clears it, but a clamp in the same cycle still wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= (start_c ? 1'b0 : ovf_reg)
                     | (s1_valid_reg & (|acc_clip))
                     | (load_c & (|out_clip));
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_addr  = out_addr_reg;
    assign drain_done    = drain_done_reg;
    assign ovf           = ovf_reg;
    assign busy          = busy_c;

endmodule

// File: tb/tb_backend_accum_engine.sv
// Directed bench for backend_accum_engine with LANES=2, RED=4, ACC_W=20.
module tb_backend_accum_engine;
    localparam int PROD_W = 17;
    localparam int LANES  = 2;
    localparam int RED    = 4;
    localparam int ACC_W  = 20;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int OUT_W  = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              drain_start = 1'b0;
    logic [ADDR_W:0]   drain_count = '0;
    logic [5:0]        drain_shift = '0;
    logic              drain_done, ovf, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [LANES*OUT_W-1:0] got_data [16];
    int                     got_addr [16];
    int                     hs_n, done_n;
    bit                     pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit                     found;

    backend_accum_engine_if #(
        .PROD_W(PROD_W), .LANES(LANES), .RED(RED), .ADDR_W(ADDR_W), .OUT_W(OUT_W)
    ) bus ();

    backend_accum_engine #(
        .PROD_W(PROD_W), .LANES(LANES), .RED(RED), .ACC_W(ACC_W),
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_W(OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .drain_start (drain_start),
        .drain_count (drain_count),
        .drain_shift (drain_shift),
        .drain_done  (drain_done),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] lane_of(input logic [LANES*OUT_W-1:0] d, input int l);
        return $signed(d[l*OUT_W +: OUT_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat: every lane gets products {p0, p_rest, p_rest, p_rest}.
    task automatic beat(input int addr, input bit first, input int p_rest, input int p0);
        for (int k = 0; k < LANES * RED; k++) begin
            bus.in_products[k*PROD_W +: PROD_W] = PROD_W'((k % RED == 0) ? p0 : p_rest);
        end
        bus.in_addr  = ADDR_W'(addr);
        bus.in_first = first;
        bus.in_valid = 1'b1;
        chk("in_ready_at_beat", bus.in_ready, 1);
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Run a drain; records each handshaked word and counts drain_done pulses.
    task automatic drain(input int cnt, input int sh, input bit use_pat);
        int pi, cyc;
        bit stalled, done_seen, r;
        logic [LANES*OUT_W-1:0] held_d;
        logic [ADDR_W-1:0]      held_a;
        pi = 0; cyc = 0; stalled = 0; done_seen = 0; hs_n = 0; done_n = 0;
        held_d = '0; held_a = '0;
        bus.out_ready = 1'b0;
        drain_count = (ADDR_W+1)'(cnt);
        drain_shift = 6'(sh);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        while (!done_seen && cyc < 100) begin
            if (bus.out_valid) begin
                if (stalled) begin
                    chk("stall_data_stable", bus.out_data, held_d);
                    chk("stall_addr_stable", bus.out_addr, held_a);
                end
                r = use_pat ? pat[pi % 6] : 1'b1;
                pi++;
                bus.out_ready = r;
                if (r) begin
                    if (hs_n < 16) begin
                        got_data[hs_n] = bus.out_data;
                        got_addr[hs_n] = int'(bus.out_addr);
                    end
                    hs_n++;
                    stalled = 0;
                end else begin
                    held_d  = bus.out_data;
                    held_a  = bus.out_addr;
                    stalled = 1;
                end
            end else begin
                bus.out_ready = 1'b0;
            end
            tick();
            cyc++;
            if (drain_done) begin
                done_seen = 1;
                done_n++;
                chk("valid_low_with_done", bus.out_valid, 0);
            end
        end
        chk("drain_within_budget", done_seen, 1);
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            if (drain_done) done_n++;
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_products = '0;
        bus.in_addr     = '0;
        bus.in_first    = 1'b0;
        bus.out_ready   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_addr", bus.out_addr, 0);
        chk("rst_drain_done", drain_done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Overwrite then accumulate: 12 per beat, three beats -> 36
        for (int a = 0; a < 5; a++) beat(a, 1'b1, 0, 0);
        beat(5, 1'b1, 3, 3);
        beat(5, 1'b0, 3, 3);
        beat(5, 1'b0, 3, 3);
        bus.in_valid = 1'b0;
        chk("busy_after_beat", busy, 1);
        idle(3);
        chk("busy_settled", busy, 0);
        drain(6, 0, 1'b0);
        chk("acc_hs_count", hs_n, 6);
        chk("acc_done_count", done_n, 1);
        chk("acc_addr5", got_addr[5], 5);
        chk("acc_lane0", lane_of(got_data[5], 0), 36);
        chk("acc_lane1", lane_of(got_data[5], 1), 36);
        chk("acc_entry0_zero", lane_of(got_data[0], 0), 0);
        chk("acc_ovf_clear", ovf, 0);

        // Saturation: 262140 per beat, third beat clamps to 524287
        beat(1, 1'b1, 65535, 65535);
        beat(1, 1'b0, 65535, 65535);
        beat(1, 1'b0, 65535, 65535);
        idle(3);
        chk("sat_ovf_set", ovf, 1);
        drain(2, 0, 1'b0);
        chk("sat_lane0", lane_of(got_data[1], 0), 65535);
        chk("sat_lane1", lane_of(got_data[1], 1), 65535);
        chk("sat_ovf_after_drain", ovf, 1);

        // Rounding shift
        beat(0, 1'b1, 0, 7);
        beat(1, 1'b1, 0, -7);
        idle(3);
        drain(2, 1, 1'b0);
        chk("rnd_pos7_sh1", lane_of(got_data[0], 0), 4);
        chk("rnd_neg7_sh1", lane_of(got_data[1], 0), -3);
        chk("rnd_neg7_sh1_l1", lane_of(got_data[1], 1), -3);
        chk("ovf_cleared_by_start", ovf, 0);
        beat(0, 1'b1, 0, 5);
        idle(3);
        drain(1, 2, 1'b0);
        chk("rnd_5_sh2", lane_of(got_data[0], 0), 1);
        chk("count1_hs", hs_n, 1);
        drain(0, 2, 1'b0);
        chk("count0_hs", hs_n, 1);
        chk("count0_val", lane_of(got_data[0], 1), 1);

        // Back-to-back beats to one address: 1+2+3+4
        beat(0, 1'b1, 0, 1);
        beat(0, 1'b0, 0, 2);
        beat(0, 1'b0, 0, 3);
        beat(0, 1'b0, 0, 4);
        idle(3);
        drain(1, 0, 1'b0);
        chk("b2b_lane0", lane_of(got_data[0], 0), 10);
        chk("b2b_lane1", lane_of(got_data[0], 1), 10);

        // Backpressure with ready pattern 1,0,0,1,0,1
        beat(0, 1'b1, 0, 11);
        beat(1, 1'b1, 0, 22);
        beat(2, 1'b1, 0, 33);
        idle(3);
        drain(3, 0, 1'b1);
        chk("bp_hs_count", hs_n, 3);
        chk("bp_done_count", done_n, 1);
        chk("bp_data0", lane_of(got_data[0], 0), 11);
        chk("bp_data1", lane_of(got_data[1], 1), 22);
        chk("bp_data2", lane_of(got_data[2], 0), 33);
        chk("bp_addr2", got_addr[2], 2);

        // Reset mid-drain while entry 1 is presented
        beat(3, 1'b1, 0, 44);
        idle(3);
        drain_count = 5'd4;
        drain_shift = 6'd0;
        drain_start = 1'b1;
        tick();
        drain_start   = 1'b0;
        bus.out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (bus.out_valid && bus.out_addr == 4'd1) found = 1;
            else tick();
        end
        chk("mid_drain_entry1_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        drain(4, 0, 1'b0);
        chk("restart_hs", hs_n, 4);
        chk("restart_addr0", got_addr[0], 0);
        chk("restart_data0", lane_of(got_data[0], 0), 11);
        chk("restart_data3", lane_of(got_data[3], 1), 44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/backend_accum_engine.md
# backend_accum_engine

Parametrised successor to the fixed-width backend. It reduces each beat of multiplier products through a registered adder tree and accumulates the per-lane sums into an internal accumulator buffer with signed saturation. On command it drains the buffer through a valid/ready port, applying an average-pool right shift with rounding and saturation. It sits between the multiplier array and the DDR writer, replacing the adder-tree/arbiter/accumulator chain with a handshaked, depth- and lane-configurable block.

## Interface
- PROD_W, 17, signed product width
- LANES, 16, accumulator lanes (sums per beat)
- RED, 4, products reduced per lane per beat (power of 2, ≥2)
- ACC_W, 44, signed accumulator width
- DEPTH, 256, accumulator entries per lane
- ADDR_W, $clog2(DEPTH), entry address width
- OUT_W, 17, signed drained width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  product beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_products  in  LANES*RED*PROD_W  lane l uses products [l*RED .. l*RED+RED-1]
- in_addr  in  ADDR_W  entry updated by this beat (shared by all lanes)
- in_first  in  1  1: entry := sum (overwrite); 0: entry := entry + sum
- drain_start  in  1  start drain, sampled in IDLE only
- drain_count  in  ADDR_W+1  entries to drain (1..DEPTH; 0 treated as 1)
- drain_shift  in  6  right shift applied on drain (avg pool)
- out_valid  out  1  drained word valid
- out_ready  in  1  consumer ready
- out_data  out  LANES*OUT_W  drained lanes
- out_addr  out  ADDR_W  entry index of out_data
- drain_done  out  1  one-cycle pulse after the last drained handshake
- ovf  out  1  sticky: any accumulate or drain saturated; cleared by drain_start
- busy  out  1  state != IDLE or pipeline non-empty

## Operation
- FSM: IDLE, FLUSH, DRAIN.
- IDLE: in_ready=1. On drain_start go to FLUSH, latching count, shift, and ovf clear. A beat accepted in the same cycle is still processed.
- FLUSH: in_ready=0. Wait until both pipeline stages are empty (≤2 cycles), then go to DRAIN with rd_ptr=0.
- DRAIN: in_ready=0. Emit entry rd_ptr; advance on out_valid & out_ready. After handshake on entry count-1: pulse drain_done, return to IDLE.
- Stage S1 (registered): each lane sums RED sign-extended products. Width is PROD_W+log2(RED), so no overflow is possible.
- Stage S2 (registered): read-modify-write of mem[addr][lane]. Uses sign-extended sum to ACC_W, then a saturating add clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A clamp sets ovf.
- Memory read is combinational within S2, so back-to-back beats to the same address need no forwarding.
- Drain math per lane: (acc + (shift ? 2^(shift-1) : 0)) >>> shift, computed at ACC_W+1 bits, then saturated to OUT_W. A clamp sets ovf.
- Memory contents are not reset. Software uses in_first on the first beat per entry.

## Timing
- Beat accepted at edge t: S1 registered at t+1, memory written at t+2. busy stays high through t+2.
- Full throughput is one beat per cycle in IDLE.
- out_data/out_addr are registered, loaded one cycle after DRAIN entry or after each handshake. They are held stable while out_valid & !out_ready.
- out_valid drops in the cycle after the final handshake, coincident with drain_done=1.
- Reset values (async assert):
  - state=IDLE, pipeline valids=0
  - in_ready=1 after release
  - out_valid=0, out_data=0, out_addr=0
  - drain_done=0, ovf=0, busy=0
- Reset mid-drain or mid-pipeline aborts everything. Memory keeps its undefined/previous content.
- drain_start outside IDLE is ignored.

## Structure
- Package backend_pkg: saturate functions (sat_acc, sat_out), the FSM state enum, and the rounding-shift function.
- One sub-module: backend_reduce_lane (RED-input registered adder tree, PROD_W in, PROD_W+log2(RED) out), instantiated LANES times.
- Accumulator memory stays as a register array in the top module.

## Test plan
- Overwrite then accumulate (LANES=2, RED=4), all products=3 to addr 5:
  - in_first=1, then two in_first=0 beats.
  - Drain count 6, shift 0: out_addr 5 gives 36 per lane.
- Saturation: ACC_W=20 with repeated +max products. Entry clamps at 524287, ovf=1. Drain with shift 0 to OUT_W=17 outputs 65535.
- Rounding shift: entry 7, shift 1 gives 4; entry -7, shift 1 gives -3; entry 5, shift 2 gives 1.
- Back-to-back same address: 4 consecutive beats to addr 0, sums 1, 2, 3, 4, first=1 on the first. Drain gives 10, with no bubble on in_ready.
- Backpressure: drain 3 entries while toggling out_ready 1,0,0,1,0,1. out_data stays stable while stalled, exactly 3 handshakes occur, drain_done pulses once.
- Reset mid-drain: assert reset during entry 1 of 4. out_valid=0 immediately, state=IDLE; a new drain_start restarts at out_addr 0.
